substitui_bytes_inversa: RTL

Iterative AES inverse byte-substitution unit (InvSubBytes) for the decryption datapath. It is the counterpart of the forward substitution stage. It accepts a 128-bit state through a valid/ready handshake and applies the inverse S-box to all 16 bytes using a configurable number of table lookups per cycle. It presents the result through a second valid/ready handshake. It sits between the inverse ShiftRows and AddRoundKey stages of the decryption round.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/caixa_s_inversa.sv | 11 +
 rtl/substitui_bytes_inversa.sv | 104 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte-substitution constants, state encoding and parameter check.
package aes_pkg;

   localparam int N_BYTES_BLOCO = 16;

   typedef enum logic [1:0] {
      OCIOSO,
      PROCESSANDO,
      CONCLUIDO
   } estado_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] SBOX_INV [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic bit bytes_por_ciclo_legal(input int b);
      return b == 1 || b == 2 || b == 4 || b == 8 || b == 16;
   endfunction

endpackage

// File: rtl/caixa_s_inversa.sv
// caixa_s_inversa: single combinational AES inverse S-box lookup.
module caixa_s_inversa
   import aes_pkg::*;
(
   input  logic [7:0] entrada,
   output logic [7:0] saida
);

   assign saida = SBOX_INV[entrada];

endmodule

// File: rtl/substitui_bytes_inversa.sv
// substitui_bytes_inversa: iterative AES InvSubBytes, BYTES_POR_CICLO lookups per cycle.
// Optional forward-S-box self-check of each result under SUBSTITUI_BYTES_INVERSA_VERIFICA_EN.
module substitui_bytes_inversa
   import aes_pkg::*;
#(
   parameter int BYTES_POR_CICLO = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] bloco,
   input  logic         entrada_valida,
   output logic         entrada_pronta,
   output logic [127:0] saida,
   output logic         saida_valida,
   input  logic         saida_pronta,
   output logic         erro_verificacao
);

   localparam int B = BYTES_POR_CICLO;
   localparam int N_GRUPOS = N_BYTES_BLOCO / B;
   localparam int CW = (N_GRUPOS > 1) ? $clog2(N_GRUPOS) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(N_GRUPOS - 1);

   if (!bytes_por_ciclo_legal(B)) begin : g_param_ilegal
      $error("BYTES_POR_CICLO must be 1, 2, 4, 8 or 16");
   end

   estado_t estado;
   logic [127:0] trabalho, proximo;
   logic [8*B-1:0] grupo, subst;
   logic [CW-1:0] contador;
   logic valida;

   always_comb grupo = trabalho[int'(contador)*8*B +: 8*B];

   for (genvar g = 0; g < B; g++) begin : g_caixa
      caixa_s_inversa u_caixa (
         .entrada(grupo[8*g +: 8]),
         .saida  (subst[8*g +: 8])
      );
   end

   always_comb begin
      proximo = trabalho;
      proximo[int'(contador)*8*B +: 8*B] = subst;
   end

   assign entrada_pronta = (estado == OCIOSO);
   assign saida = trabalho;
   assign saida_valida = valida;

   // contador holds on the last group instead of wrapping; every accept clears it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         estado   <= OCIOSO;
         trabalho <= '0;
         contador <= '0;
         valida   <= 1'b0;
      end else if (estado == OCIOSO) begin
         if (entrada_valida) begin
            trabalho <= bloco;
            contador <= '0;
            estado   <= PROCESSANDO;
         end
      end else if (estado == PROCESSANDO) begin
         trabalho <= proximo;
         if (contador == ULTIMO) begin
            estado <= CONCLUIDO;
            valida <= 1'b1;
         end else
            contador <= contador + 1'b1;
      end else if (saida_pronta) begin
         estado <= OCIOSO;
         valida <= 1'b0;
      end

`ifdef SUBSTITUI_BYTES_INVERSA_VERIFICA_EN
   logic [127:0] original;
   logic confere, erro;

   // checks the value being written on the final edge, so the flag lines up with saida_valida
   always_comb begin
      confere = 1'b1;
      for (int i = 0; i < N_BYTES_BLOCO; i++)
         if (SBOX[proximo[8*i +: 8]] != original[8*i +: 8]) confere = 1'b0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         original <= '0;
         erro     <= 1'b0;
      end else if (estado == OCIOSO && entrada_valida)
         original <= bloco;
      else if (estado == PROCESSANDO && contador == ULTIMO)
         erro <= !confere;
      else if (estado == CONCLUIDO && saida_pronta)
         erro <= 1'b0;

   assign erro_verificacao = erro;
`else
   assign erro_verificacao = 1'b0;
`endif

endmodule
